// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and digit bundle between the result register and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH = 14
);
  logic                start;
  logic [IN_WIDTH-1:0] bin_in;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [3:0]          digit3;
  logic [3:0]          digit2;
  logic [3:0]          digit1;
  logic [3:0]          digit0;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, digit3, digit2, digit1, digit0
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, digit3, digit2, digit1, digit0
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Bit-serial double-dabble converter: one input bit per clock into a 5-digit
// BCD scratch, with the display digits only updated once the result is final.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bin_to_bcd_seq_if.slave        bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam int         NDIG     = 5;

  logic [1:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q,   bin_d;
  logic [19:0]         scr_q,   scr_d;
  logic [19:0]         scr_adj;
  logic [4:0]          cnt_q,   cnt_d;
  logic [15:0]         dig_q,   dig_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                ovf_q,   ovf_d;

  // Add-3 correction per digit, independent lanes (no inter-digit carry).
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                          : scr_q[4*g +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        // busy stays up through the done cycle; a start sampled at its
        // closing edge is accepted, giving back-to-back conversions.
        busy_d = bus.start;
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = 5'(IN_WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d = {scr_adj[18:0], bin_q[IN_WIDTH-1]};
        bin_d = {bin_q[IN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_FINISH;
      end
      S_FINISH: begin
        dig_d   = scr_q[15:0];
        ovf_d   = (scr_q[19:16] != 4'd0) || (scr_q[15:12] > 4'd9);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digit3   = dig_q[15:12];
  assign bus.digit2   = dig_q[11:8];
  assign bus.digit1   = dig_q[7:4];
  assign bus.digit0   = dig_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 14-bit and 16-bit builds side by side, each
// checked every cycle against an edge-count/decimal model plus literal cases.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin_to_bcd_seq_if #(.IN_WIDTH(14)) ifa();
  bin_to_bcd_seq_if #(.IN_WIDTH(16)) ifb();

  bin_to_bcd_seq #(.IN_WIDTH(14)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bin_to_bcd_seq #(.IN_WIDTH(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Uniform views of both builds, index 0 = 14-bit, 1 = 16-bit.
  int          wid [2];
  logic        st  [2];
  int          bi  [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_ovf  [2];
  logic [15:0] o_dig  [2];

  assign st[0]     = ifa.start;
  assign st[1]     = ifb.start;
  assign bi[0]     = int'(ifa.bin_in);
  assign bi[1]     = int'(ifb.bin_in);
  assign o_busy[0] = ifa.busy;
  assign o_busy[1] = ifb.busy;
  assign o_done[0] = ifa.done;
  assign o_done[1] = ifb.done;
  assign o_ovf[0]  = ifa.overflow;
  assign o_ovf[1]  = ifb.overflow;
  assign o_dig[0]  = {ifa.digit3, ifa.digit2, ifa.digit1, ifa.digit0};
  assign o_dig[1]  = {ifb.digit3, ifb.digit2, ifb.digit1, ifb.digit0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Low four decimal digits of v, packed one per nibble.
  function automatic logic [15:0] dec4(input int v);
    int r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  // Model: age counts edges since the accepted start (-1 when idle).
  int          m_age [2];
  int          m_val [2];
  logic [15:0] m_dig [2];
  logic        m_ovf [2];

  initial begin
    wid[0] = 14;
    wid[1] = 16;
    for (int d = 0; d < 2; d++) begin
      m_age[d] = -1; m_val[d] = 0; m_dig[d] = '0; m_ovf[d] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_age[d] = -1; m_dig[d] = '0; m_ovf[d] = 1'b0;
      end else begin
        if (m_age[d] >= 0) m_age[d]++;
        if ((m_age[d] < 0 || m_age[d] == wid[d] + 2) && st[d] === 1'b1) begin
          m_age[d] = 0;
          m_val[d] = bi[d];
        end else if (m_age[d] == wid[d] + 2) begin
          m_age[d] = -1;
        end
        if (m_age[d] == wid[d] + 1) begin
          m_dig[d] = dec4(m_val[d]);
          m_ovf[d] = (m_val[d] > 9999);
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("model_busy%0d", d), 32'(o_busy[d]), 32'(m_age[d] >= 0));
      chk($sformatf("model_done%0d", d), 32'(o_done[d]), 32'(m_age[d] == wid[d] + 1));
      chk($sformatf("model_dig%0d", d),  32'(o_dig[d]),  32'(m_dig[d]));
      chk($sformatf("model_ovf%0d", d),  32'(o_ovf[d]),  32'(m_ovf[d]));
    end
  end

  task automatic drive(input int d, input logic s, input int v);
    if (d == 0) begin ifa.start = s; ifa.bin_in = 14'(v); end
    else        begin ifb.start = s; ifb.bin_in = 16'(v); end
  endtask

  // Called just after a clock edge with the DUT idle.
  task automatic conv(input int d, input int v, input logic [15:0] exp_dig, input logic exp_ovf);
    int n;
    n = 0;
    drive(d, 1'b1, v);
    @(posedge clk); #1;
    drive(d, 1'b0, 0);
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(posedge clk); #1;
      if (o_done[d] === 1'b1) n = k;
    end
    chk($sformatf("lat%0d_%0d", d, v), 32'(n), 32'(wid[d] + 1));
    chk($sformatf("dig%0d_%0d", d, v), 32'(o_dig[d]), 32'(exp_dig));
    chk($sformatf("ovf%0d_%0d", d, v), 32'(o_ovf[d]), 32'(exp_ovf));
    @(posedge clk); #1;
    chk($sformatf("busy_end%0d_%0d", d, v), 32'(o_busy[d]), 32'd0);
  endtask

  int          dk[$];
  logic [15:0] dd[$];
  int          ndone;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ifa.start = 1'b0; ifa.bin_in = '0;
    ifb.start = 1'b0; ifb.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_ovf",  32'(ifa.overflow), 32'd0);
    chk("rst_dig",  32'(o_dig[0]), 32'h0);
    rst_n = 1'b1;

    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (o_done[0] === 1'b1 || o_done[1] === 1'b1) ndone++;
    end
    chk("idle_no_done", 32'(ndone), 32'd0);

    conv(0, 1234,  16'h1234, 1'b0);
    conv(0, 0,     16'h0000, 1'b0);
    conv(0, 9999,  16'h9999, 1'b0);
    conv(0, 10000, 16'h0000, 1'b1);
    conv(0, 16383, 16'h6383, 1'b1);

    // Starts during busy (E+5, FINISH cycle) are dropped; E+16 is accepted.
    drive(0, 1'b1, 1234);
    for (int k = 0; k <= 36; k++) begin
      @(posedge clk); #1;
      if (o_done[0] === 1'b1) begin dk.push_back(k); dd.push_back(o_dig[0]); end
      drive(0, (k + 1 == 5 || k + 1 == 15 || k + 1 == 16), 5678);
    end
    chk("ign_count", 32'(dk.size()), 32'd2);
    if (dk.size() == 2) begin
      chk("ign_k0",   32'(dk[0]), 32'd15);
      chk("ign_dig0", 32'(dd[0]), 32'h1234);
      chk("ign_k1",   32'(dk[1]), 32'd31);
      chk("ign_dig1", 32'(dd[1]), 32'h5678);
    end

    // Reset mid-conversion aborts it and clears the display digits.
    conv(0, 4321, 16'h4321, 1'b0);
    drive(0, 1'b1, 987);
    @(posedge clk); #1;
    drive(0, 1'b0, 0);
    ndone = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (o_done[0] === 1'b1) ndone++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_done[0] === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_busy",    32'(o_busy[0]), 32'd0);
    chk("abort_dig",     32'(o_dig[0]), 32'h0);
    conv(0, 987, 16'h0987, 1'b0);

    conv(1, 65535, 16'h5535, 1'b1);
    conv(1, 9999,  16'h9999, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      int v;
      v = int'($urandom_range(0, 65535));
      conv(1, v, dec4(v), (v > 9999));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
